// File: rtl/onehot_decoder_pipe.sv
// onehot_decoder_pipe: registered binary-to-one-hot decoder with a ready/valid
// handshake on both sides and an auto-scan mode that walks a single bit
// across the outputs, advancing once every SCAN_DIV cycles.
module onehot_decoder_pipe #(
  parameter int AW       = 2,
  parameter int N_OUT    = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    addr,
  input  logic             scan,
  output logic [N_OUT-1:0] D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  // The divider must be able to hold SCAN_DIV-1 for every legal SCAN_DIV.
  localparam int               CW       = $clog2(SCAN_DIV + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(SCAN_DIV - 1);
  // One bit wider than addr so that N_OUT == 2**AW is still representable.
  localparam logic [AW:0]      ADDR_LIM = (AW + 1)'(N_OUT);
  localparam logic [N_OUT-1:0] D_FIRST  = N_OUT'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t           r_state;
  logic [N_OUT-1:0] r_d;
  logic             r_out_valid;
  logic             r_err;
  logic [CW-1:0]    r_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_addr_ok;
  logic [N_OUT-1:0] w_dec;

  // One-hot of a; an address at or beyond N_OUT yields all zeros.
  function automatic logic [N_OUT-1:0] f_onehot(input logic [AW-1:0] a);
    logic [N_OUT-1:0] v;
    v = '0;
    for (int i = 0; i < N_OUT; i++) begin
      v[i] = (a == AW'(i)) ? 1'b1 : 1'b0;
    end
    return v;
  endfunction

  // Ready depends only on state, the consumer and reset, never on in_valid.
  always_comb begin
    w_in_ready = 1'b0;
    if (!rst_n) begin
      w_in_ready = 1'b0;
    end else begin
      case (r_state)
        IDLE:    w_in_ready = 1'b1;
        HOLD:    w_in_ready = out_ready;
        SCAN:    w_in_ready = 1'b0;
        default: w_in_ready = 1'b0;
      endcase
    end
  end

  // Decode the incoming address and qualify the accept (scan has priority).
  always_comb begin
    w_addr_ok = ({1'b0, addr} < ADDR_LIM) ? 1'b1 : 1'b0;
    w_dec     = f_onehot(addr);
    w_accept  = in_valid & w_in_ready & ~scan;
  end

  // Control FSM and output registers: decode hold, back-to-back reload, scan walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_d         <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (scan) begin
            r_state     <= SCAN;
            r_d         <= D_FIRST;
            r_out_valid <= 1'b1;
            r_err       <= 1'b0;
            r_cnt       <= '0;
          end else if (w_accept) begin
            r_state     <= HOLD;
            r_d         <= w_dec;
            r_out_valid <= 1'b1;
            r_err       <= ~w_addr_ok;
          end else begin
            r_state     <= IDLE;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (scan) begin
              r_state     <= SCAN;
              r_d         <= D_FIRST;
              r_out_valid <= 1'b1;
              r_err       <= 1'b0;
              r_cnt       <= '0;
            end else if (w_accept) begin
              r_state     <= HOLD;
              r_d         <= w_dec;
              r_out_valid <= 1'b1;
              r_err       <= ~w_addr_ok;
            end else begin
              r_state     <= IDLE;
              r_d         <= '0;
              r_out_valid <= 1'b0;
              r_err       <= 1'b0;
            end
          end else begin
            r_state <= HOLD;
          end
        end
        SCAN: begin
          if (!scan) begin
            r_state     <= IDLE;
            r_d         <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
          end else if (r_cnt == CNT_LAST) begin
            // Step only when the consumer takes the current position.
            if (out_ready) begin
              r_d   <= {r_d[N_OUT-2:0], r_d[N_OUT-1]};
              r_cnt <= '0;
            end else begin
              r_cnt <= CNT_LAST;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_d         <= '0;
          r_out_valid <= 1'b0;
          r_err       <= 1'b0;
          r_cnt       <= '0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign D         = r_d;
  assign out_valid = r_out_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Directed bench for onehot_decoder_pipe: one instance with AW=2/N_OUT=4/
// SCAN_DIV=2 and one with AW=3/N_OUT=5/SCAN_DIV=1, hand-computed expectations.
module tb_onehot_decoder_pipe;

  logic       clk;
  logic       rst_n;

  logic       iv0, ir0, scan0, ordy0, ov0, err0;
  logic [1:0] addr0;
  logic [3:0] d0;

  logic       iv1, ir1, scan1, ordy1, ov1, err1;
  logic [2:0] addr1;
  logic [4:0] d1;

  int n_vec;
  int n_err;

  onehot_decoder_pipe #(.AW(2), .N_OUT(4), .SCAN_DIV(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .addr(addr0),
    .scan(scan0), .D(d0), .out_valid(ov0), .out_ready(ordy0), .err(err0)
  );

  onehot_decoder_pipe #(.AW(3), .N_OUT(5), .SCAN_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .addr(addr1),
    .scan(scan1), .D(d1), .out_valid(ov1), .out_ready(ordy1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] scan_seq0 [9];
  logic [4:0] scan_seq1 [5];

  initial begin
    n_vec = 0;
    n_err = 0;
    scan_seq0 = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                  4'b0100, 4'b1000, 4'b1000, 4'b0001};
    scan_seq1 = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

    rst_n = 1'b0;
    iv0 = 1'b0; addr0 = 2'd0; scan0 = 1'b0; ordy0 = 1'b0;
    iv1 = 1'b0; addr1 = 3'd0; scan1 = 1'b0; ordy1 = 1'b0;

    // Reset state
    #3;
    chk("rst_d", 32'(d0), 32'h0);
    chk("rst_ov", 32'(ov0), 32'h0);
    chk("rst_err", 32'(err0), 32'h0);
    chk("rst_ir", 32'(ir0), 32'h0);
    #4 rst_n = 1'b1;
    #1;
    chk("idle_ir", 32'(ir0), 32'h1);

    // Basic decode
    iv0 = 1'b1; addr0 = 2'd2; ordy0 = 1'b1;
    step();
    iv0 = 1'b0;
    chk("dec_d", 32'(d0), 32'h4);
    chk("dec_ov", 32'(ov0), 32'h1);
    chk("dec_err", 32'(err0), 32'h0);
    step();
    chk("drain_d", 32'(d0), 32'h0);
    chk("drain_ov", 32'(ov0), 32'h0);

    // Backpressure then back-to-back reload
    iv0 = 1'b1; addr0 = 2'd3; ordy0 = 1'b0;
    step();
    iv0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_d", 32'(d0), 32'h8);
      chk("bp_ov", 32'(ov0), 32'h1);
      chk("bp_ir", 32'(ir0), 32'h0);
      step();
    end
    ordy0 = 1'b1; iv0 = 1'b1; addr0 = 2'd0;
    #1;
    chk("b2b_ir", 32'(ir0), 32'h1);
    step();
    iv0 = 1'b0;
    chk("b2b_d", 32'(d0), 32'h1);
    chk("b2b_ov", 32'(ov0), 32'h1);
    step();
    chk("b2b_drain", 32'(ov0), 32'h0);

    // Scan walk with SCAN_DIV=2, then exit (in_valid ignored on exit edge)
    scan0 = 1'b1; ordy0 = 1'b1;
    step();
    chk("scan_ir", 32'(ir0), 32'h0);
    chk("scan_ov", 32'(ov0), 32'h1);
    chk("scan_d0", 32'(d0), 32'(scan_seq0[0]));
    for (int i = 1; i < 9; i++) begin
      step();
      chk("scan_d", 32'(d0), 32'(scan_seq0[i]));
    end
    scan0 = 1'b0; iv0 = 1'b1; addr0 = 2'd1;
    step();
    iv0 = 1'b0;
    chk("scanx_d", 32'(d0), 32'h0);
    chk("scanx_ov", 32'(ov0), 32'h0);

    // Scan stall
    scan0 = 1'b1; ordy0 = 1'b1;
    step();
    chk("stall_entry", 32'(d0), 32'h1);
    ordy0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stall_d", 32'(d0), 32'h1);
    end
    ordy0 = 1'b1;
    step();
    chk("stall_adv", 32'(d0), 32'h2);
    scan0 = 1'b0;
    step();
    chk("stall_exit", 32'(ov0), 32'h0);

    // Out-of-range and top-boundary decode on N_OUT=5
    iv1 = 1'b1; addr1 = 3'd4; ordy1 = 1'b1;
    step();
    addr1 = 3'd6;
    chk("edge_d", 32'(d1), 32'h10);
    chk("edge_err", 32'(err1), 32'h0);
    chk("edge_ir", 32'(ir1), 32'h1);
    step();
    iv1 = 1'b0;
    chk("oor_d", 32'(d1), 32'h0);
    chk("oor_ov", 32'(ov1), 32'h1);
    chk("oor_err", 32'(err1), 32'h1);
    step();
    chk("oor_clr_err", 32'(err1), 32'h0);
    chk("oor_clr_ov", 32'(ov1), 32'h0);
    iv1 = 1'b1; addr1 = 3'd5; ordy1 = 1'b0;
    step();
    iv1 = 1'b0;
    step();
    chk("oor_hold_err", 32'(err1), 32'h1);
    chk("oor_hold_ov", 32'(ov1), 32'h1);
    ordy1 = 1'b1;
    step();
    chk("oor_rel_ov", 32'(ov1), 32'h0);

    // Scan with SCAN_DIV=1: advance every ready cycle, wrap within 5 bits
    scan1 = 1'b1; ordy1 = 1'b1;
    step();
    chk("s1_entry", 32'(d1), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s1_d", 32'(d1), 32'(scan_seq1[i]));
    end
    ordy1 = 1'b0;
    step();
    chk("s1_stall", 32'(d1), 32'h1);
    ordy1 = 1'b1;
    step();
    chk("s1_adv", 32'(d1), 32'h2);
    scan1 = 1'b0;
    step();
    chk("s1_exit_d", 32'(d1), 32'h0);
    chk("s1_exit_ov", 32'(ov1), 32'h0);

    // Reset mid-operation
    iv0 = 1'b1; addr0 = 2'd3; ordy0 = 1'b0;
    iv1 = 1'b1; addr1 = 3'd7; ordy1 = 1'b0;
    step();
    iv0 = 1'b0; iv1 = 1'b0;
    chk("pre_rst_d", 32'(d0), 32'h8);
    chk("pre_rst_err", 32'(err1), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_d", 32'(d0), 32'h0);
    chk("arst_ov", 32'(ov0), 32'h0);
    chk("arst_err", 32'(err1), 32'h0);
    chk("arst_ov1", 32'(ov1), 32'h0);
    chk("arst_ir", 32'(ir0), 32'h0);
    #2 rst_n = 1'b1;
    iv0 = 1'b1; addr0 = 2'd1; ordy0 = 1'b1;
    #1;
    chk("post_rst_ir", 32'(ir0), 32'h1);
    step();
    iv0 = 1'b0;
    chk("post_rst_d", 32'(d0), 32'h2);
    chk("post_rst_ov", 32'(ov0), 32'h1);
    chk("post_rst_err", 32'(err0), 32'h0);
    chk("post_rst_ov1", 32'(ov1), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_pipe.md
ONEHOT_DECODER_PIPE -- requirements
Module: onehot_decoder_pipe

Interface
REQ-001 SHALL have parameter AW, default 2: address width in bits, range 1..6.
REQ-002 SHALL have parameter N_OUT, default 4: number of decoded outputs, range 2..2**AW.
REQ-003 SHALL have parameter SCAN_DIV, default 4: cycles per scan step, range 1..256.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1: addr holds a request.
REQ-007 SHALL have port in_ready  output  1: block accepts a request this cycle.
REQ-008 SHALL have port addr  input  AW: binary select.
REQ-009 SHALL have port scan  input  1: level; 1 requests auto-scan mode.
REQ-010 SHALL have port D  output  N_OUT: registered one-hot (or zero) output.
REQ-011 SHALL have port out_valid  output  1: D is valid.
REQ-012 SHALL have port out_ready  input  1: consumer takes D this cycle.
REQ-013 SHALL have port err  output  1: registered, set with D when the accepted addr is >= N_OUT.

Function
REQ-014 SHALL implement a state machine with states IDLE, HOLD, SCAN.
REQ-015 SHALL drive in_ready = 1 in IDLE, in_ready = out_ready in HOLD, and in_ready = 0 in SCAN; in_ready is combinational, with no dependency on in_valid.
REQ-016 SHALL accept a request when in_valid && in_ready && !scan, and on that edge:
- D <= one-hot of addr (bit addr set);
- out_valid <= 1;
- err <= 0;
- state <= HOLD.
Latency is 1 cycle from accept to out_valid.
REQ-017 SHALL, for an accepted addr >= N_OUT, load D <= 0 with out_valid <= 1 and err <= 1.
REQ-018 SHALL hold D, err and out_valid stable in HOLD while out_ready = 0.
REQ-019 SHALL handle out_ready = 1 in HOLD as follows:
- With a simultaneous accept: the new D/err load on that edge (back-to-back, no bubble).
- With no accept: D <= 0, err <= 0, out_valid <= 0, state <= IDLE.
REQ-020 SHALL enter SCAN from IDLE when scan = 1; scan takes priority over in_valid in IDLE.
REQ-021 SHALL enter SCAN from HOLD only when the held item is taken (out_ready = 1) and scan = 1.
REQ-022 SHALL set, on SCAN entry: D <= 1 (bit 0), out_valid <= 1, err <= 0, divider count <= 0.
REQ-023 SHALL run the divider in SCAN as follows:
- The divider counts 0..SCAN_DIV-1.
- At SCAN_DIV-1 with out_ready = 1: D rotates left by one within N_OUT bits (bit N_OUT-1 wraps to bit 0) and the count returns to 0.
- At SCAN_DIV-1 with out_ready = 0: the count holds at SCAN_DIV-1 and D holds.
REQ-024 SHALL, with SCAN_DIV = 1, advance D on every cycle that has out_ready = 1.
REQ-025 SHALL exit SCAN when scan = 0: next edge D <= 0, out_valid <= 0, count <= 0, state <= IDLE; in_valid is ignored on that edge.
REQ-026 SHALL keep D either zero or exactly one-hot at all times, never with more than one bit set.
REQ-027 SHALL size the divider counter as ceil(log2(SCAN_DIV+1)) bits, with no overflow for any legal SCAN_DIV.

Reset
REQ-028 SHALL, while rst_n = 0, force regardless of clk: D = 0, out_valid = 0, err = 0, count = 0, state = IDLE.
REQ-029 SHALL drive in_ready = 0 while rst_n = 0.
REQ-030 SHALL discard any pending HOLD item or scan position when reset asserts mid-operation; after release, the first edge behaves as IDLE.

Verification
REQ-031 SHALL pass a basic decode test, AW=2, N_OUT=4: accept addr=2 with out_ready=1 -> next cycle D=4'b0100, out_valid=1, err=0; following cycle, with no new request, D=0 and out_valid=0.
REQ-032 SHALL pass a backpressure test: accept addr=3, hold out_ready=0 for 5 cycles -> D=4'b1000 stable and in_ready=0 throughout; raise out_ready together with in_valid and addr=0 -> next cycle D=4'b0001.
REQ-033 SHALL pass an out-of-range test, AW=3, N_OUT=5: accept addr=6 -> D=5'b00000, out_valid=1, err=1.
REQ-034 SHALL pass a scan test, N_OUT=4, SCAN_DIV=2, out_ready=1: assert scan in IDLE -> D sequence 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001 (wrap); drop scan -> next cycle D=0, out_valid=0.
REQ-035 SHALL pass a scan-stall test: in SCAN, out_ready=0 for 6 cycles -> D frozen; on out_ready=1, D advances on the first such edge.
REQ-036 SHALL pass a reset-mid-operation test: assert rst_n=0 asynchronously in HOLD between clock edges -> D, out_valid and err go to 0 immediately; after release, addr=1 is accepted -> D=4'b0010.
